btn_gesture_fsm: RTL and testbench
==================================

Name: btn_gesture_fsm

Overview:
Consumes the debounced, synchronised button level from the debouncer. Classifies activity into single-cycle event pulses: press, release, single click, double click, long press and auto-repeat. Also provides a held level for UI/game logic.
All outputs are registered and sit in the system clock domain. The block feeds the menu/game controllers directly.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
LONG_PRESS_MS, 800, hold time before long_press fires
DOUBLE_GAP_MS, 300, max release-to-press gap for a double click
REPEAT_MS, 150, auto-repeat period after long_press; 0 disables repeat
Derived:
- LONG_COUNT = (CLK_FREQ/1000)*LONG_PRESS_MS
- GAP_COUNT = (CLK_FREQ/1000)*DOUBLE_GAP_MS
- REPEAT_COUNT = (CLK_FREQ/1000)*REPEAT_MS
- LONG_COUNT and GAP_COUNT must both be >= 2. The counter width is $clog2 of the largest count, plus 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_db  in  1  debounced button level (already synchronous to clk)
press_pulse  out  1  one cycle on every sampled rising edge of btn_db
release_pulse  out  1  one cycle on every sampled falling edge of btn_db
single_click  out  1  one cycle when a short press is not followed by a second press within the gap
double_click  out  1  one cycle on release of the second short press
long_press  out  1  one cycle when a hold reaches LONG_COUNT
repeat_pulse  out  1  one cycle every REPEAT_COUNT cycles after long_press while still held
held  out  1  level; high in PRESSED, LONG_HELD and SECOND_PRESSED

Behaviour:
Reset:
- rst_n low asynchronously clears all outputs, the counter and btn_q, and sets state to IDLE.
- A btn_db that is high when reset is released is treated as a fresh press on the first edge.

Edges and latency:
- btn_q holds btn_db from the previous edge.
- rise = btn_db & ~btn_q; fall = ~btn_db & btn_q.
- Edge k is the first edge sampling btn_db high: press_pulse is high for the cycle after edge k. The same 1-cycle latency applies to release_pulse.

States:
- IDLE: on rise, go to PRESSED and set cnt=1.
- PRESSED: cnt increments each edge.
  - Fall: go to WAIT_GAP, cnt=1.
  - btn high and cnt==LONG_COUNT, i.e. edge k+LONG_COUNT: assert long_press, go to LONG_HELD, cnt=1.
  - Release sampled on that same edge: release wins, no long_press.
- LONG_HELD:
  - While held, repeat_pulse fires at edges k+LONG_COUNT+n*REPEAT_COUNT, n>=1, and cnt reloads to 1 at each pulse.
  - Fall: go to IDLE. No click events follow a long press.
- WAIT_GAP: cnt increments each edge.
  - Rise at any edge with cnt<=GAP_COUNT: go to SECOND_PRESSED, cnt=1. A rise wins a tie at cnt==GAP_COUNT.
  - cnt==GAP_COUNT with btn low: assert single_click, go to IDLE.
- SECOND_PRESSED:
  - Fall before LONG_COUNT: assert double_click, go to IDLE.
  - Held to LONG_COUNT: assert long_press, go to LONG_HELD. The double click is cancelled.

Always true:
- press_pulse and release_pulse fire on every edge in every state, independent of classification.
- Every event output is exactly one cycle wide.
- At most one of single_click, double_click and long_press fires per edge.
- Counters saturate and never wrap.
- Reset mid-gesture abandons the gesture and emits no pending event.

Decomposition:
- Shared package btn_pkg holds:
  - the state enum: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED
  - the ms_to_cycles constant function
  - the count-width helper
- One sub-module is natural: edge_detect (clk, rst_n, d, rise, fall), reusable for switch inputs elsewhere.

Test Plan:
All scenarios use CLK_FREQ=1000 (1 cycle/ms), LONG_PRESS_MS=8, DOUBLE_GAP_MS=3, REPEAT_MS=2.
- btn high 4 cycles then low -> press_pulse at edge k, release_pulse at k+4, single_click exactly 3 cycles after release edge, no double or long.
- high 2, low 2, high 2, low -> two press_pulses, double_click one cycle after second release edge, no single_click.
- high 13 cycles -> long_press at k+8, repeat_pulse at k+10 and k+12, held high throughout, no click on release.
- low gap of exactly 3 cycles, rise on the tie edge -> SECOND_PRESSED path taken, double_click on next release, no single_click.
- rst_n pulsed low mid-WAIT_GAP -> all outputs 0 immediately, no single_click afterwards.
- btn_db held high through reset release -> press_pulse on first edge after reset.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type and constant helpers for the button gesture classifier
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_PRESSED
  } btn_state_e;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

  // One spare bit above the largest count so saturation never aliases a terminal value.
  function automatic int count_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered previous level with combinational rise/fall strobes
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // Cleared to 0 so a level already high at reset release reads as a rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/btn_gesture_fsm.sv
// rtl/btn_gesture_fsm.sv - classifies a debounced button into press/release/click/long/repeat pulses
module btn_gesture_fsm
  import btn_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int LONG_PRESS_MS = 800,
  parameter int DOUBLE_GAP_MS = 300,
  parameter int REPEAT_MS     = 150
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_db_i,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic single_click_o,
  output logic double_click_o,
  output logic long_press_o,
  output logic repeat_pulse_o,
  output logic held_o
);

  localparam int LONG_COUNT   = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
  localparam int GAP_COUNT    = ms_to_cycles(CLK_FREQ, DOUBLE_GAP_MS);
  localparam int REPEAT_COUNT = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int CW           = count_width(LONG_COUNT, GAP_COUNT, REPEAT_COUNT);

  localparam logic [CW-1:0] LONG_C  = CW'(LONG_COUNT);
  localparam logic [CW-1:0] GAP_C   = CW'(GAP_COUNT);
  localparam logic [CW-1:0] REP_C   = CW'(REPEAT_COUNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic rise, fall;

  edge_detect u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_db_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          press_q, release_q, single_q, double_q, long_q, repeat_q, held_q;
  logic          single_d, double_d, long_d, repeat_d, held_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = CNT_ONE;
        end
      end
      PRESSED, SECOND_PRESSED: begin
        // A release on the long-press edge takes priority over the long press.
        if (fall) begin
          double_d = (state_q == SECOND_PRESSED);
          state_d  = (state_q == PRESSED) ? WAIT_GAP : IDLE;
          cnt_d    = CNT_ONE;
        end else if (btn_db_i && cnt_q == LONG_C) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REPEAT_COUNT != 0 && cnt_q == REP_C) begin
          repeat_d = 1'b1;
          cnt_d    = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_GAP: begin
        // A second press on the final gap cycle still counts as a double click.
        if (rise) begin
          state_d = SECOND_PRESSED;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == GAP_C) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == SECOND_PRESSED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= rise;
      release_q <= fall;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign single_click_o  = single_q;
  assign double_click_o  = double_q;
  assign long_press_o    = long_q;
  assign repeat_pulse_o  = repeat_q;
  assign held_o          = held_q;

endmodule

// File: tb/tb_btn_gesture_fsm.sv
// tb/tb_btn_gesture_fsm.sv - vector table and scoreboard bench for btn_gesture_fsm
module tb_btn_gesture_fsm;

  localparam int B_PRESS  = 6;
  localparam int B_REL    = 5;
  localparam int B_SINGLE = 4;
  localparam int B_DOUBLE = 3;
  localparam int B_LONG   = 2;
  localparam int B_REP    = 1;
  localparam int B_HELD   = 0;

  typedef struct {
    logic       rst_n;
    logic       btn;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic press_o, release_o, single_o, double_o, long_o, repeat_o, held_o;

  vec_t       vecs[$];
  logic [6:0] sb[$];
  string      sb_tag[$];
  logic       prev_btn;
  string      cur_tag;
  int         n_checks = 0;
  int         n_pass = 0;
  int         k;

  always #5 clk = ~clk;

  btn_gesture_fsm #(
    .CLK_FREQ      (1000),
    .LONG_PRESS_MS (8),
    .DOUBLE_GAP_MS (3),
    .REPEAT_MS     (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .btn_db_i        (btn),
    .press_pulse_o   (press_o),
    .release_pulse_o (release_o),
    .single_click_o  (single_o),
    .double_click_o  (double_o),
    .long_press_o    (long_o),
    .repeat_pulse_o  (repeat_o),
    .held_o          (held_o)
  );

  // Press/release/held follow directly from the sampled level; gesture events are marked by hand.
  task automatic add(input logic r, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst_n = r;
      v.btn   = b;
      v.exp   = '0;
      v.tag   = cur_tag;
      if (r) begin
        v.exp[B_PRESS] = b & ~prev_btn;
        v.exp[B_REL]   = ~b & prev_btn;
        v.exp[B_HELD]  = b;
        prev_btn = b;
      end else begin
        prev_btn = 1'b0;
      end
      vecs.push_back(v);
    end
  endtask

  task automatic evt(input int idx, input int b);
    vecs[idx].exp[b] = 1'b1;
  endtask

  task automatic check(input logic [6:0] exp, input string tag, input int idx);
    logic [6:0] got;
    got = {press_o, release_o, single_o, double_o, long_o, repeat_o, held_o};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got press/rel/single/dbl/long/rep/held=%b required %b", tag, idx, got, exp);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      btn   = vecs[i].btn;
      sb.push_back(vecs[i].exp);
      sb_tag.push_back(vecs[i].tag);
      @(posedge clk);
      #1;
      check(sb.pop_front(), sb_tag.pop_front(), i);
    end
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    btn = 1'b0;
    prev_btn = 1'b0;

    cur_tag = "reset";
    add(0, 0, 3);

    cur_tag = "single";
    add(1, 0, 2);
    k = vecs.size();
    add(1, 1, 4); add(1, 0, 6);
    evt(k + 7, B_SINGLE);

    cur_tag = "double";
    k = vecs.size();
    add(1, 1, 2); add(1, 0, 2); add(1, 1, 2); add(1, 0, 5);
    evt(k + 6, B_DOUBLE);

    cur_tag = "long_repeat";
    k = vecs.size();
    add(1, 1, 13); add(1, 0, 4);
    evt(k + 8, B_LONG); evt(k + 10, B_REP); evt(k + 12, B_REP);

    cur_tag = "gap_tie";
    k = vecs.size();
    add(1, 1, 2); add(1, 0, 3); add(1, 1, 2); add(1, 0, 5);
    evt(k + 7, B_DOUBLE);

    cur_tag = "release_on_long_edge";
    k = vecs.size();
    add(1, 1, 8); add(1, 0, 6);
    evt(k + 11, B_SINGLE);

    cur_tag = "second_press_long";
    k = vecs.size();
    add(1, 1, 2); add(1, 0, 2); add(1, 1, 10); add(1, 0, 4);
    evt(k + 12, B_LONG);

    cur_tag = "held_through_reset";
    add(0, 1, 2);
    k = vecs.size();
    add(1, 1, 4); add(1, 0, 5);
    evt(k + 7, B_SINGLE);

    run_vecs();

    // Reset asserted between edges while a single click is pending in the gap.
    cur_tag = "mid_gap_reset";
    add(1, 1, 2); add(1, 0, 1);
    run_vecs();
    rst_n = 1'b0;
    #2;
    check(7'b0, "rst_async", 0);
    add(0, 0, 2); add(1, 0, 6);
    run_vecs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
